// File: rtl/conv_acc_buf_pkg.sv
// Shared widths and accumulator lane type for the convolution accumulate buffer.
package GLOBAL_PARAM;
    localparam int BATCH = 4;
    localparam int MAC_W = 16;
    localparam int ACC_W = 32;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic acc_t sext_mac(input logic [MAC_W-1:0] d);
        return {{(ACC_W-MAC_W){d[MAC_W-1]}}, d};
    endfunction
endpackage

// File: rtl/conv_acc_buf_ram.sv
// Simple dual-port accumulate RAM: 1-cycle synchronous read, returns old data on a same-cycle write.
module acc_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_acc_buf.sv
// Two-stage read-modify-write accumulate buffer with a drain read port.
// Optional lane saturation and sticky sat_flag when ACC_SAT_EN is defined.
module conv_acc_buf
    import GLOBAL_PARAM::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [BATCH-1:0]         in_acc_en,
    input  logic                     in_acc_new,
    input  logic [BATCH*MAC_W-1:0]   in_data,
    output logic                     busy,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [BATCH*ACC_W-1:0]   rd_data
`ifdef ACC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);
    logic                   s1_valid, s1_new, fwd;
    logic [ADDR_W-1:0]      s1_addr;
    logic [BATCH-1:0]       s1_en;
    logic [BATCH*MAC_W-1:0] s1_data;
    logic [BATCH*ACC_W-1:0] ram_rdata, wdata, fwd_data;
    logic [ADDR_W-1:0]      raddr;

    // Accumulate traffic owns the single read port; drains only get it when idle.
    assign raddr    = in_valid ? in_addr : rd_addr;
    assign busy     = s1_valid;
    assign rd_ready = rd_req & ~in_valid & ~s1_valid;
    assign rd_data  = rd_valid ? ram_rdata : '0;

    acc_ram #(.ADDR_W(ADDR_W), .DATA_W(BATCH*ACC_W)) u_ram (
        .clk   (clk),
        .we    (s1_valid),
        .waddr (s1_addr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

`ifdef ACC_SAT_EN
    logic [BATCH-1:0] lane_sat;
`endif

    for (genvar l = 0; l < BATCH; l++) begin : g_lane
        acc_t old_v, din_v, add_v;
        // RAM read of an address written the same cycle is stale; use last write data.
        assign old_v = fwd ? acc_t'(fwd_data[l*ACC_W +: ACC_W]) : acc_t'(ram_rdata[l*ACC_W +: ACC_W]);
        assign din_v = sext_mac(s1_data[l*MAC_W +: MAC_W]);
`ifdef ACC_SAT_EN
        logic [ACC_W:0] sum_v;
        logic           ovf;
        assign sum_v = {old_v[ACC_W-1], old_v} + {din_v[ACC_W-1], din_v};
        assign ovf   = sum_v[ACC_W] ^ sum_v[ACC_W-1];
        assign add_v = !ovf ? acc_t'(sum_v[ACC_W-1:0]) : (sum_v[ACC_W] ? ACC_MIN : ACC_MAX);
        assign lane_sat[l] = s1_valid & s1_en[l] & ~s1_new & ovf;
`else
        assign add_v = old_v + din_v;
`endif
        assign wdata[l*ACC_W +: ACC_W] = !s1_en[l] ? old_v : (s1_new ? din_v : add_v);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            fwd      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            fwd      <= in_valid & s1_valid & (in_addr == s1_addr);
            rd_valid <= rd_ready;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr  <= in_addr;
        s1_en    <= in_acc_en;
        s1_new   <= in_acc_new;
        s1_data  <= in_data;
        fwd_data <= wdata;
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           sat_flag <= 1'b0;
        else if (|lane_sat) sat_flag <= 1'b1;
    end
`endif
endmodule

// File: doc/conv_acc_buf.md
CONV_ACC_BUF -- requirements
Module: conv_acc_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, accumulate buffer address width.
REQ-002 SHALL take BATCH, MAC_W (16), ACC_W (32) from package GLOBAL_PARAM.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  accumulate request valid this cycle.
REQ-006 SHALL have port in_addr  input  ADDR_W  accumulate address (from conv_agu abuf_addr).
REQ-007 SHALL have port in_acc_en  input  BATCH  per-lane enable (from abuf_acc_en).
REQ-008 SHALL have port in_acc_new  input  1  overwrite instead of add (from abuf_acc_new).
REQ-009 SHALL have port in_data  input  BATCH*MAC_W  signed MAC results, lane 0 in LSBs.
REQ-010 SHALL have port busy  output  1  accumulate pipeline holds an in-flight entry.
REQ-011 SHALL have port rd_req, rd_addr  input  1, ADDR_W  drain read request and address.
REQ-012 SHALL have port rd_ready  output  1  drain request accepted this cycle.
REQ-013 SHALL have port rd_valid, rd_data  output  1, BATCH*ACC_W  drain result.

Function
REQ-014 SHALL be a 2-stage read-modify-write pipeline: S0 issues RAM read of in_addr and registers request into S1; S1 computes and writes.
REQ-015 SHALL accept in_valid every cycle with no backpressure; no input is ever dropped.
REQ-016 SHALL compute per lane: acc_new -> sign-extended in_data; else old + sign-extended in_data; lanes with acc_en=0 write old value unchanged.
REQ-017 SHALL write S1 result in cycle t+1 for a request presented in cycle t; value readable from cycle t+2.
REQ-018 SHALL forward S1 write data to the next S1 when consecutive requests have equal addresses (RAM read-before-write), so back-to-back same-address sums are exact.
REQ-019 SHALL assert busy exactly when S1 holds a valid entry.
REQ-020 SHALL assert rd_ready = rd_req & ~in_valid & ~busy; accumulate traffic has strict priority.
REQ-021 SHALL return rd_valid=1 with rd_data one cycle after rd_ready, otherwise rd_valid=0.
REQ-022 SHALL wrap additions modulo 2^ACC_W unless ACC_SAT_EN is defined.

Reset
REQ-023 SHALL on rst low clear S1 valid, forward flag, busy, rd_valid, rd_data (0), and the saturation flag.
REQ-024 SHALL not reset RAM contents; an in-flight S1 write at reset assertion is discarded.
REQ-025 SHALL accept requests in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with ACC_SAT_EN defined, clamp each lane to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and add output sat_flag (sticky, set on any clamp, cleared by reset only).
REQ-027 SHALL, without ACC_SAT_EN, wrap on overflow and have no sat_flag port.

Structure
REQ-028 SHALL place MAC_W, ACC_W and the per-lane accumulator typedef in GLOBAL_PARAM.
REQ-029 SHALL instantiate one sub-module acc_ram: simple dual-port, 2^ADDR_W x BATCH*ACC_W, 1-cycle synchronous read, read-old-data on collision.

Verification
REQ-030 SHALL cover: addr 5 acc_new=1 data 10, then addr 5 add 7 next cycle -> drain addr 5 returns 17 in every lane.
REQ-031 SHALL cover: in_acc_en=0b0001 with data 3 on addr 2 preloaded 100 -> lane0=103, other lanes 100.
REQ-032 SHALL cover: rd_req held while in_valid streams 4 cycles -> rd_ready low until stream end plus 1 cycle, then rd_valid next cycle.
REQ-033 SHALL cover: lane at 0x7FFFFFFF plus 1 -> 0x80000000 without ACC_SAT_EN; 0x7FFFFFFF and sat_flag=1 with it.
REQ-034 SHALL cover: rst low mid-stream with S1 valid -> busy=0, rd_valid=0 next cycle; post-reset addr 9 acc_new 4 reads back 4.
REQ-035 SHALL cover: alternating addrs 1,2,1,2 add 1 each for 8 cycles after acc_new 0 -> both read 4.
